// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// denomination index type, coin count width and the denomination value table.
package change_dispenser_pkg;

  localparam int unsigned COUNT_W   = 8;
  localparam int unsigned NUM_DENOM = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [1:0]         denom_t;
  typedef logic [COUNT_W-1:0] count_t;

  // Index 0 is the largest coin so a lowest-index-first search is greedy
  localparam logic [6:0] DENOM_VALUE [NUM_DENOM] = '{7'd20, 7'd10, 7'd5, 7'd1};

  function automatic logic [6:0] denom_value(input denom_t d);
    return DENOM_VALUE[d];
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change dispenser request/ejection/refill/status bundle.
// master: requester + coin mechanism side; slave: the dispenser.
interface change_dispenser_if;
  logic       start;
  logic [6:0] change_amount;
  logic       abort;
  logic       eject_ack;
  logic       refill;
  logic [1:0] refill_denom;
  logic [7:0] refill_count;
  logic       eject_req;
  logic [1:0] eject_denom;
  logic       busy;
  logic       done;
  logic [6:0] shortfall;
  logic       timeout;
  logic [3:0] low_stock;
  logic [1:0] state;

  modport master (
    output start, change_amount, abort, eject_ack, refill, refill_denom, refill_count,
    input  eject_req, eject_denom, busy, done, shortfall, timeout, low_stock, state
  );

  modport slave (
    input  start, change_amount, abort, eject_ack, refill, refill_denom, refill_count,
    output eject_req, eject_denom, busy, done, shortfall, timeout, low_stock, state
  );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Four saturating coin counters. A refill and an ejection of the same
// denomination in one cycle merge into a single update.
module coin_inventory
  import change_dispenser_pkg::*;
#(
  parameter int unsigned INIT_COUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    refill,
  input  denom_t                  refill_denom,
  input  count_t                  refill_count,
  input  logic                    dec,
  input  denom_t                  dec_denom,
  output count_t [NUM_DENOM-1:0]  count,
  output logic   [NUM_DENOM-1:0]  low_stock
);

  count_t [NUM_DENOM-1:0] count_next;
  logic   [COUNT_W+1:0]   sum;

  // Merge refill and decrement per denomination, clamp at full scale
  always_comb begin
    count_next = count;
    low_stock  = '0;
    sum        = '0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      sum = {2'b00, count[i]};
      if (refill && refill_denom == denom_t'(i))
        sum = sum + {2'b00, refill_count};
      if (dec && dec_denom == denom_t'(i))
        sum = sum - 1'b1;
      count_next[i] = (sum > {2'b00, {COUNT_W{1'b1}}}) ? '1 : sum[COUNT_W-1:0];
      low_stock[i]  = (count[i] == '0);
    end
  end

  // Counter registers, loaded with INIT_COUNT on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DENOM; i++)
        count[i] <= count_t'(INIT_COUNT);
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays change_amount one coin at a time through an
// eject_req/eject_ack handshake, largest available coin first.
// Optional ack timeout: define CHANGE_DISPENSER_TIMEOUT_EN.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned INIT_COUNT     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  change_dispenser_if.slave    bus
);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t                 state, state_next;
  logic   [6:0]           remaining;
  logic   [6:0]           shortfall;
  denom_t                 eject_denom;
  logic                   timeout_r;
  logic                   abort_lat;
  logic   [TW-1:0]        tcnt;
  count_t [NUM_DENOM-1:0] cnt;
  logic   [NUM_DENOM-1:0] low_stock;

  logic   load, pick_go, take_ack, finish, to_hit, found, tmo_reached;
  denom_t pick_idx;

  assign tmo_reached = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  coin_inventory #(.INIT_COUNT(INIT_COUNT)) u_inv (
    .clk          (clk),
    .rst          (rst),
    .refill       (bus.refill),
    .refill_denom (bus.refill_denom),
    .refill_count (bus.refill_count),
    .dec          (take_ack),
    .dec_denom    (eject_denom),
    .count        (cnt),
    .low_stock    (low_stock)
  );

  // Next-state decision and datapath strobes for the payout sequence
  always_comb begin
    state_next = state;
    load       = 1'b0;
    pick_go    = 1'b0;
    take_ack   = 1'b0;
    finish     = 1'b0;
    to_hit     = 1'b0;
    found      = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (!found && denom_value(denom_t'(i)) <= remaining && cnt[i] != '0) begin
        found    = 1'b1;
        pick_idx = denom_t'(i);
      end
    end
    case (state)
      IDLE: if (bus.start) begin
        load       = 1'b1;
        state_next = SELECT;
      end
      SELECT: begin
        // remaining==0 also lands here, giving shortfall 0
        if (remaining == '0 || abort_lat || bus.abort || !found) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          pick_go    = 1'b1;
          state_next = EJECT;
        end
      end
      EJECT: begin
        if (bus.eject_ack) begin
          take_ack   = 1'b1;
          state_next = SELECT;
        end else if (TIMEOUT_EN && tmo_reached) begin
          to_hit     = 1'b1;
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Payout datapath: remaining, shortfall, selected coin, abort and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      shortfall   <= '0;
      eject_denom <= '0;
      timeout_r   <= 1'b0;
      abort_lat   <= 1'b0;
      tcnt        <= '0;
    end else begin
      if (load) begin
        remaining <= bus.change_amount;
        shortfall <= '0;
        timeout_r <= 1'b0;
      end
      if (take_ack) remaining   <= remaining - denom_value(eject_denom);
      if (pick_go)  eject_denom <= pick_idx;
      if (finish)   shortfall   <= remaining;
      if (to_hit)   timeout_r   <= 1'b1;
      if (state == IDLE)  abort_lat <= 1'b0;
      else if (bus.abort) abort_lat <= 1'b1;
      if (state != EJECT) tcnt <= '0;
      else                tcnt <= tcnt + 1'b1;
    end
  end

  assign bus.eject_req   = (state == EJECT);
  assign bus.eject_denom = eject_denom;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.shortfall   = shortfall;
  assign bus.timeout     = TIMEOUT_EN ? timeout_r : 1'b0;
  assign bus.low_stock   = low_stock;
  assign bus.state       = state;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have one clock (clk) and a synchronous, active-high reset (rst); no other clocks or resets.
REQ-002 SHALL have parameter INIT_COUNT, default 8: coins per denomination loaded on reset, 0..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum wait for eject_ack when timeout is compiled in.
REQ-004 SHALL have ports:
  - clk  in  1  clock
  - rst  in  1  sync active-high reset
  - start  in  1  request payout of change_amount; sampled in IDLE only
  - change_amount  in  7  change owed, 0..127
  - abort  in  1  stop payout after the coin in flight
  - eject_ack  in  1  mechanism has ejected the requested coin
  - refill  in  1  add refill_count coins of refill_denom
  - refill_denom  in  2  denomination index
  - refill_count  in  8  coins added
  - eject_req  out  1  coin ejection request
  - eject_denom  out  2  denomination requested
  - busy  out  1  high in every state except IDLE
  - done  out  1  one-cycle completion pulse
  - shortfall  out  7  change not paid; valid from done until next accepted start
  - timeout  out  1  last payout ended by ack timeout
  - low_stock  out  4  bit i high when count[i] == 0
  - state  out  2  current FSM state

Function
REQ-005 Denomination index and value SHALL be: 0 = 20, 1 = 10, 2 = 5, 3 = 1.
REQ-006 The FSM SHALL have four states: IDLE=0, SELECT=1, EJECT=2, DONE=3.
REQ-007 In IDLE, when start=1, the block SHALL latch change_amount into remaining, clear shortfall and timeout, and enter SELECT on the next cycle.
REQ-008 SELECT SHALL last exactly one cycle.
  - remaining == 0 or abort latched: go to DONE.
  - Otherwise pick the lowest index with value <= remaining and count > 0, register it on eject_denom, and enter EJECT with eject_req=1.
  - No such denomination: go to DONE with shortfall = remaining.
REQ-009 In EJECT, eject_req and eject_denom SHALL stay stable until eject_ack is sampled high.
  - On that edge: remaining -= value, count[eject_denom] -= 1, eject_req drops, and the FSM returns to SELECT.
REQ-010 DONE SHALL last one cycle with done=1 and return to IDLE; shortfall SHALL hold until the next accepted start.
REQ-011 start SHALL be ignored when busy=1; eject_ack SHALL be ignored outside EJECT.
REQ-012 abort SHALL be latched in any busy state and SHALL NOT cut a pending handshake.
  - The next SELECT goes to DONE with shortfall = remaining.
  - The latch clears in IDLE.
REQ-013 refill SHALL be accepted in any state.
  - If it coincides with a decrement of the same denomination: count = count + refill_count - 1.
  - All count updates SHALL saturate at 255.
REQ-014 start with change_amount == 0 SHALL give done two cycles after start, with shortfall 0 and no eject_req.

Reset
REQ-015 On rst the block SHALL go to IDLE.
  - eject_req, done, busy and timeout = 0; shortfall = 0; eject_denom = 0.
  - Every count = INIT_COUNT; the abort latch is cleared.
REQ-016 rst during EJECT SHALL drop eject_req on the same edge and SHALL NOT decrement any count.

Configuration
REQ-017 With CHANGE_DISPENSER_TIMEOUT_EN defined, the block SHALL count cycles in EJECT.
  - If eject_ack has not arrived after TIMEOUT_CYCLES cycles: drop eject_req, leave the count unchanged, set timeout=1, and go to DONE with shortfall = remaining.
REQ-018 Without CHANGE_DISPENSER_TIMEOUT_EN, EJECT SHALL wait indefinitely and timeout SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-019 Package change_dispenser_pkg SHALL hold the state enum, the 2-bit denomination type, the denomination value table, and the count width.
REQ-020 The four saturating counters, with refill/decrement merge and low_stock, SHALL be sub-module coin_inventory.

Verification
REQ-021 Reset, start amount 37, ack each coin after 1 cycle -> eject_denom sequence 0,1,2,3,3; done; shortfall 0; counts 7,7,7,6.
REQ-022 INIT_COUNT=0, refill denom 1 by 1, start 25 -> one 10 coin ejected, then done with shortfall 15; low_stock = 4'b1111.
REQ-023 Start 37, ack delayed 5 cycles, second start pulse while busy -> eject_req and eject_denom stable for 5 cycles; second start ignored.
REQ-024 Start 37, abort during the first EJECT, then ack -> 20 ejected, done with shortfall 17, no further eject_req.
REQ-025 With the timeout macro defined, start 37, no ack -> eject_req drops after 15 cycles; timeout=1; shortfall 37; count[0] unchanged.
REQ-026 count[0]=255, refill denom 0 by 10 on the same cycle as a denom-0 ack -> count[0]=255; rst mid-EJECT -> IDLE, eject_req=0, counts = INIT_COUNT.
